// File: rtl/des_req_arbiter.sv
// Two-channel round-robin request arbiter in front of one shared DES core.
// One job in flight; core timeout yields an error response.
module des_req_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [63:0] din0,
  input  logic [63:0] key0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [63:0] din1,
  input  logic [63:0] key1,
  output logic        gnt1,
  output logic        core_start,
  output logic [63:0] core_desIn,
  output logic [63:0] core_keyIn,
  input  logic        core_ready,
  input  logic [63:0] core_desOut,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  input  logic        rsp_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RESP,
    S_REL
  } state_t;

  localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic [63:0] din_q, din_d;
  logic [63:0] key_q, key_d;
  logic [63:0] data_q, data_d;
  logic        id_q, id_d;
  logic        err_q, err_d;
  logic        any_req;
  logic        pick;

  // Round-robin pick: on a tie the channel not granted last wins.
  always_comb begin
    any_req = req0 | req1;
    pick    = (req0 & req1) ? ~last_q : req1;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    din_d   = din_q;
    key_d   = key_q;
    data_d  = data_q;
    id_d    = id_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          din_d   = pick ? din1 : din0;
          key_d   = pick ? key1 : key0;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          id_d    = pick;
          last_d  = pick;
          cnt_d   = 8'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        if (core_ready) begin
          data_d  = core_desOut;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == TO_M1) begin
          data_d  = 64'h0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_REL;
      end
      S_REL: begin
        if (!core_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      din_q   <= 64'h0;
      key_q   <= 64'h0;
      data_q  <= 64'h0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      din_q   <= din_d;
      key_q   <= key_d;
      data_q  <= data_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign core_start = (state_q == S_RUN);
  assign core_desIn = din_q;
  assign core_keyIn = key_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;

endmodule
